// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// Holds the default address/data widths and the FSM state encoding.
package mem_arb_pkg;

  localparam int unsigned AW_DEF = 12;
  localparam int unsigned DW_DEF = 16;

  // One transaction: IDLE samples requests, ACCESS drives memory, RESP returns read data
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter, one instance per requester.
//   req/we/addr/wdata : request from the requester (held until gnt is seen)
//   gnt               : high for the single ACCESS cycle of the transaction
//   rvalid/rdata      : one-cycle read data return
// master = requester side, slave = arbiter side.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector (purely combinational).
//   reqs        : request vector, bit i = requester i
//   prio        : requester that wins a tie
//   any_c       : at least one request present
//   winner_c    : selected requester (valid when any_c)
//   prio_next_c : priority after this grant (the non-winner)
module rr_pick2 (
  input  logic [1:0] reqs,
  input  logic       prio,
  output logic       any_c,
  output logic       winner_c,
  output logic       prio_next_c
);

  always_comb begin
    any_c       = |reqs;
    winner_c    = (&reqs) ? prio : reqs[1];
    prio_next_c = ~winner_c;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one single-port synchronous memory.
//   clk, rst   : clock, synchronous active-high reset
//   m0, m1     : requester buses (m0 = processor, m1 = I/O or DMA)
//   mem_addr   : memory address (non-zero only in ACCESS)
//   mem_wdata  : memory write data (non-zero only in ACCESS)
//   mem_we     : memory write strobe (ACCESS of a write only)
//   mem_rdata  : memory read data, valid the cycle after the address
// A write takes ACCESS->IDLE, a read ACCESS->RESP->IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          id_q, id_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          pick_any;
  logic          pick_winner;
  logic          pick_prio_next;

  rr_pick2 u_pick (
    .reqs        ({m1.req, m0.req}),
    .prio        (prio_q),
    .any_c       (pick_any),
    .winner_c    (pick_winner),
    .prio_next_c (pick_prio_next)
  );

  // Next state and transaction latch
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_ACCESS;
          prio_d  = pick_prio_next;
          id_d    = pick_winner;
          we_d    = pick_winner ? m1.we    : m0.we;
          addr_d  = pick_winner ? m1.addr  : m0.addr;
          wdata_d = pick_winner ? m1.wdata : m0.wdata;
        end
      end
      ST_ACCESS: state_d = we_q ? ST_IDLE : ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from next state so they land registered
  always_comb begin
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rv0_d       = 1'b0;
    rv1_d       = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == ST_ACCESS) begin
      gnt0_d      = ~id_d;
      gnt1_d      = id_d;
      mem_we_d    = we_d;
      mem_addr_d  = addr_d;
      mem_wdata_d = wdata_d;
    end
    if (state_d == ST_RESP) begin
      rv0_d = ~id_d;
      rv1_d = id_d;
    end
  end

  // State, latch and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rv0_q       <= 1'b0;
      rv1_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rv0_q       <= rv0_d;
      rv1_q       <= rv1_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign m0.gnt    = gnt0_q;
  assign m1.gnt    = gnt1_q;
  assign m0.rvalid = rv0_q;
  assign m1.rvalid = rv1_q;
  // Memory data arrives in RESP; the registered rvalid gates it to the winner only
  assign m0.rdata  = rv0_q ? mem_rdata : '0;
  assign m1.rdata  = rv1_q ? mem_rdata : '0;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants/reads into
// queues, a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW      = AW_DEF;
  localparam int unsigned DW      = DW_DEF;
  localparam int unsigned TIMEOUT = 50;

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_exp_t;

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  gnt_exp_t gnt_q[$];
  rd_exp_t  rd_q[$];
  int       checks    = 0;
  int       failures  = 0;
  int       gnt_count = 0;
  bit       mon_en    = 1'b0;
  bit       pend_rd   = 1'b0;
  bit       pend_port = 1'b0;
  bit       prev_we   = 1'b0;
  bit       rst_at_edge = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Single-port synchronous memory: read data registered, one cycle after the address
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  always @(posedge clk) rst_at_edge <= rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks every cycle's outputs against the scoreboard and bus rules
  always @(negedge clk) begin
    logic     g0, g1, exp_rv0, exp_rv1;
    gnt_exp_t e;
    rd_exp_t  r;
    if (mon_en) begin
      g0 = m0_bus.gnt;
      g1 = m1_bus.gnt;
      chk("gnt_exclusive", 32'(g0 & g1), 32'd0);
      exp_rv0 = pend_rd && !pend_port && !rst_at_edge;
      exp_rv1 = pend_rd &&  pend_port && !rst_at_edge;
      chk("rvalid0_timing", 32'(m0_bus.rvalid), 32'(exp_rv0));
      chk("rvalid1_timing", 32'(m1_bus.rvalid), 32'(exp_rv1));
      chk("mem_we_consecutive", 32'(mem_we & prev_we), 32'd0);
      if (!m0_bus.rvalid) chk("rdata0_quiet", 32'(m0_bus.rdata), 32'd0);
      if (!m1_bus.rvalid) chk("rdata1_quiet", 32'(m1_bus.rdata), 32'd0);
      if (!g0 && !g1)
        chk("mem_bus_outside_access", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
      if (g0 || g1) begin
        gnt_count++;
        if (gnt_q.size() == 0) begin
          chk("unexpected_gnt", 32'({g1, g0}), 32'd0);
        end else begin
          e = gnt_q.pop_front();
          chk("gnt_port", 32'(g1), 32'(e.port));
          chk("gnt_mem_we", 32'(mem_we), 32'(e.we));
          chk("gnt_mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("gnt_mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
      end
      if (m0_bus.rvalid || m1_bus.rvalid) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_rvalid", 32'({m1_bus.rvalid, m0_bus.rvalid}), 32'd0);
        end else begin
          r = rd_q.pop_front();
          chk("rd_port", 32'(m1_bus.rvalid), 32'(r.port));
          chk("rd_data", r.port ? 32'(m1_bus.rdata) : 32'(m0_bus.rdata), 32'(r.rdata));
        end
      end
      pend_rd   = (g0 || g1) && !mem_we;
      pend_port = g1;
      prev_we   = mem_we;
    end
  end

  task automatic set_req(input logic port, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port) begin
      m1_bus.req = req; m1_bus.we = we; m1_bus.addr = addr; m1_bus.wdata = wdata;
    end else begin
      m0_bus.req = req; m0_bus.we = we; m0_bus.addr = addr; m0_bus.wdata = wdata;
    end
  endtask

  task automatic expect_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    gnt_exp_t e;
    rd_exp_t  r;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
    gnt_q.push_back(e);
    if (!we) begin
      r.port = port; r.rdata = rdata;
      rd_q.push_back(r);
    end
  endtask

  // Raise a request and wait (bounded) for its grant; lat = negedges until gnt seen
  task automatic drive(input logic port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input bit hold, output int lat);
    logic g;
    int   n;
    g = 1'b0;
    n = 0;
    set_req(port, 1'b1, we, addr, wdata);
    while (!g && n < int'(TIMEOUT)) begin
      @(negedge clk);
      n++;
      g = port ? m1_bus.gnt : m0_bus.gnt;
    end
    if (!g) chk("gnt_timeout", 32'(g), 32'd1);
    if (!hold) set_req(port, 1'b0, we, addr, wdata);
    lat = n;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid, mem_we}), 32'd0);
    chk({tag, "_rdata"}, 32'({m0_bus.rdata, m1_bus.rdata}), 32'd0);
    chk({tag, "_mem_bus"}, 32'({mem_addr, mem_wdata}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat0, lat1, g_before;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[12'h020] = 16'h1234;
    mem[12'hFFF] = 16'h5A5A;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    idle(1);

    // Request dropped before the sampling edge is never granted
    g_before = gnt_count;
    m0_bus.req = 1'b1;
    #2 m0_bus.req = 1'b0;
    idle(4);
    chk("glitch_no_gnt", 32'(gnt_count), 32'(g_before));

    // Single write
    expect_txn(1'b0, 1'b1, 12'h010, 16'hBEEF, '0);
    drive(1'b0, 1'b1, 12'h010, 16'hBEEF, 1'b0, lat);
    chk("write_latency", 32'(lat), 32'd1);
    idle(3);
    chk("write_committed", 32'(mem[12'h010]), 32'h0000BEEF);

    // Single read by m1
    expect_txn(1'b1, 1'b0, 12'h020, 16'h0000, 16'h1234);
    drive(1'b1, 1'b0, 12'h020, 16'h0000, 1'b0, lat);
    chk("read_latency", 32'(lat), 32'd1);
    idle(3);

    // Continuous contention from reset: m0, m1, m0, m1
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    expect_txn(1'b0, 1'b1, 12'h100, 16'hA0A0, '0);
    expect_txn(1'b1, 1'b0, 12'h100, 16'h0000, 16'hA0A0);
    expect_txn(1'b0, 1'b1, 12'h101, 16'hA0A1, '0);
    expect_txn(1'b1, 1'b0, 12'h101, 16'h0000, 16'hA0A1);
    fork
      begin
        int l;
        drive(1'b0, 1'b1, 12'h100, 16'hA0A0, 1'b1, l);
        drive(1'b0, 1'b1, 12'h101, 16'hA0A1, 1'b0, l);
      end
      begin
        int l;
        drive(1'b1, 1'b0, 12'h100, 16'h0000, 1'b1, l);
        drive(1'b1, 1'b0, 12'h101, 16'h0000, 1'b0, l);
      end
    join
    idle(4);

    // m1 raises its request during an m0 read ACCESS
    expect_txn(1'b0, 1'b0, 12'h010, 16'h0000, 16'hBEEF);
    expect_txn(1'b1, 1'b1, 12'h030, 16'hCAFE, '0);
    lat1 = 0;
    fork
      drive(1'b0, 1'b0, 12'h010, 16'h0000, 1'b0, lat0);
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m0_bus.gnt && n < int'(TIMEOUT));
        drive(1'b1, 1'b1, 12'h030, 16'hCAFE, 1'b0, lat1);
      end
    join
    chk("late_req_latency", 32'(lat1), 32'd3);
    idle(3);
    chk("late_write_committed", 32'(mem[12'h030]), 32'h0000CAFE);

    // Reset during the ACCESS of a read: no rvalid, prio back to m0
    expect_txn(1'b0, 1'b1, 12'h020, 16'h0000, '0);
    gnt_q[gnt_q.size() - 1].we = 1'b0;
    drive(1'b0, 1'b0, 12'h020, 16'h0000, 1'b1, lat);
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 12'h020, 16'h0000);
    @(negedge clk);
    check_all_zero("rst_mid_read");
    rst = 1'b0;
    idle(3);
    expect_txn(1'b0, 1'b1, 12'h040, 16'h1111, '0);
    expect_txn(1'b1, 1'b1, 12'h041, 16'h2222, '0);
    fork
      drive(1'b0, 1'b1, 12'h040, 16'h1111, 1'b0, lat0);
      drive(1'b1, 1'b1, 12'h041, 16'h2222, 1'b0, lat1);
    join
    chk("post_reset_tie_m0_first", 32'(lat0), 32'd1);
    idle(3);

    // Write-then-read at the top address with all-zero and all-one data
    expect_txn(1'b0, 1'b1, 12'hFFF, 16'h0000, '0);
    drive(1'b0, 1'b1, 12'hFFF, 16'h0000, 1'b0, lat);
    idle(3);
    expect_txn(1'b1, 1'b0, 12'hFFF, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b0, lat);
    idle(3);
    expect_txn(1'b1, 1'b1, 12'hFFF, 16'hFFFF, '0);
    drive(1'b1, 1'b1, 12'hFFF, 16'hFFFF, 1'b0, lat);
    idle(3);
    expect_txn(1'b0, 1'b0, 12'hFFF, 16'h0000, 16'hFFFF);
    drive(1'b0, 1'b0, 12'hFFF, 16'h0000, 1'b0, lat);
    idle(5);

    chk("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 12, memory address width in bits.
REQ-002 Parameter DW, default 16, memory data width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m0_req  input  1  requester 0 (processor) access request, held until m0_gnt is seen.
REQ-006 m0_we  input  1  requester 0 write enable (1 = write, 0 = read), stable while m0_req high.
REQ-007 m0_addr  input  AW  requester 0 address, stable while m0_req high.
REQ-008 m0_wdata  input  DW  requester 0 write data, stable while m0_req high.
REQ-009 m0_gnt  output  1  requester 0 granted; high for exactly the one ACCESS cycle of its transaction.
REQ-010 m0_rvalid  output  1  requester 0 read data valid; one-cycle pulse.
REQ-011 m0_rdata  output  DW  requester 0 read data; meaningful only when m0_rvalid is high.
REQ-012 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same directions, widths and meanings for requester 1 (I/O or DMA).
REQ-013 mem_addr  output  AW  address to the single-port synchronous memory.
REQ-014 mem_wdata  output  DW  write data to memory.
REQ-015 mem_we  output  1  memory write strobe.
REQ-016 mem_rdata  input  DW  memory read data, valid on the cycle after the address is presented.

Function
REQ-017 FSM states are IDLE, ACCESS and RESP.
REQ-018 IDLE: when no req is high, stay in IDLE; when any req is high, go to ACCESS and latch the winner's id, we, addr and wdata.
REQ-019 Arbitration: a single requester wins outright; on simultaneous requests the winner is the requester named by the 1-bit priority pointer prio.
REQ-020 prio is set to the non-winner on every transition into ACCESS, giving strict alternation under continuous contention.
REQ-021 ACCESS: drive mem_addr and mem_wdata from the latched values; mem_we equals the latched we; the winner's gnt is high and the other gnt is low.
REQ-022 ACCESS with a write goes to IDLE; ACCESS with a read goes to RESP.
REQ-023 RESP: the winner's rvalid is high and its rdata equals mem_rdata; the next state is IDLE.
REQ-024 Latency from the req-sampling edge: write committed in 1 cycle, read data returned 2 cycles after that edge; a write occupies 2 cycles per transaction, a read 3.
REQ-025 In IDLE and RESP, mem_we is 0 and mem_addr and mem_wdata are 0.
REQ-026 Requests are sampled only in IDLE; a req raised during ACCESS or RESP waits without loss.
REQ-027 A req that stays high after its gnt is treated as a new request at the next IDLE.
REQ-028 A req that drops in IDLE before the sampling edge is never granted.
REQ-029 The non-winner's rdata is 0 and its rvalid and gnt are 0 at all times.
REQ-030 mem_we shall never be high outside ACCESS, and never for more than one consecutive cycle per transaction.

Reset
REQ-031 While rst is high at a rising edge: state becomes IDLE, prio becomes 0, and the latched id, we, addr and wdata become 0.
REQ-032 After reset all outputs are 0: gnt, rvalid, rdata, mem_addr, mem_wdata and mem_we.
REQ-033 Reset asserted in ACCESS or RESP aborts the transaction: no rvalid pulse is produced, and mem_we is low from the next cycle.

Structure
REQ-034 A shared package mem_arb_pkg shall hold the state encoding constants and the default AW and DW values.
REQ-035 The 2-way round-robin selection (inputs: reqs and prio; outputs: winner and next prio) shall be a combinational sub-module rr_pick2.
REQ-036 All outputs shall be decoded from registered state and latches only, with no combinational path from m*_req to mem_*.

Verification
REQ-037 Single write: m0_req=1, we=1, addr=12'h010, wdata=16'hBEEF -> next cycle m0_gnt=1, mem_we=1, mem_addr=12'h010, mem_wdata=16'hBEEF.
REQ-038 Single read: m1 reads addr 12'h020 while memory holds 16'h1234 at that address -> m1_gnt is high in cycle 1 and m1_rvalid=1 with m1_rdata=16'h1234 in cycle 2.
REQ-039 Contention after reset: m0 and m1 both request continuously -> grant order m0, m1, m0, m1, and no gnt is high for both requesters in any cycle.
REQ-040 Late request: m1_req rises during an m0 ACCESS -> m1 is granted in the ACCESS following the next IDLE, with no dropped transaction.
REQ-041 Reset mid-read: rst pulsed during ACCESS of a read -> no rvalid pulse, state IDLE, and prio=0 (m0 wins the next tie).
REQ-042 Write-then-read of 12'hFFF with data 16'h0000 then 16'hFFFF -> each read returns the last written value, and mem_we stays low outside ACCESS.
